// File: rtl/figan_stream_pkg.sv
// figan_stream_pkg
//   Shared definitions for the pixel stream feeder: the feeder FSM state
//   encoding, the default pixel width and a helper that sizes down-counters.
package figan_stream_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_PGAP,
        S_RGAP,
        S_FIN
    } feed_state_t;

    // Bits needed to hold values 0..max_val; never narrower than one bit so
    // degenerate geometries (1-pixel rows, 1-row frames) still elaborate.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/stream_gap_timer.sv
// stream_gap_timer
//   Loadable down-counter used to time the idle gaps between pixel pulses.
//   Ports:
//     clk, rst_n   clock, async active-low reset
//     load         load load_val (has priority over en)
//     en           decrement while non-zero
//     load_val     gap length minus two (the SEND and FETCH cycles bracket it)
//     expire       counter is zero; the gap ends in this cycle
module stream_gap_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/pixel_stream_feeder.sv
// pixel_stream_feeder
//   Reads an IN_HEIGHT x IN_WIDTH frame row-major from a synchronous RAM and
//   emits each pixel as a one-cycle valid_out/data_out pulse, leaving
//   PIXEL_GAP idle cycles between pulses in a row and ROW_GAP idle cycles
//   across row boundaries so the downstream upsampler can insert padding.
//   Ports:
//     clk, rst_n     clock, async active-low reset
//     start          frame request, accepted only when idle
//     hold_in        stall (only with FEEDER_HOLD_EN defined)
//     mem_rd_en      RAM read strobe (FETCH state)
//     mem_addr       RAM address row*IN_WIDTH+col
//     mem_rd_data    RAM data, one cycle after mem_rd_en
//     valid_out      pixel strobe
//     data_out       pixel value, held between pulses
//     busy           frame in progress (through the done cycle)
//     done           one-cycle pulse after the last pixel
//   Optional feature macro: FEEDER_HOLD_EN adds hold_in and a one-entry skid
//   register for a read caught in flight by a stall.
module pixel_stream_feeder
    import figan_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IN_WIDTH   = 13,
    parameter int IN_HEIGHT  = 13,
    parameter int PIXEL_GAP  = 5,
    parameter int ROW_GAP    = 100,
    parameter int ADDR_WIDTH = $clog2(IN_WIDTH * IN_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef FEEDER_HOLD_EN
    input  logic                  hold_in,
`endif
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = cnt_w(IN_WIDTH - 1);
    localparam int RW = cnt_w(IN_HEIGHT - 1);
    localparam int GW = cnt_w((PIXEL_GAP > ROW_GAP) ? PIXEL_GAP : ROW_GAP);

    localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);
    // SEND and FETCH each take one cycle of the spacing, so the gap state
    // itself lasts GAP-1 cycles: load GAP-2 and leave when the count hits 0.
    localparam logic [GW-1:0] PG_LOAD  = GW'(PIXEL_GAP - 2);
    localparam logic [GW-1:0] RG_LOAD  = GW'(ROW_GAP - 2);

    feed_state_t state, state_d;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hold;
    logic                  accept;
    logic                  send_fire;
    logic                  tmr_load;
    logic [GW-1:0]         tmr_val;
    logic                  tmr_exp;
    logic [DATA_WIDTH-1:0] pix;

`ifdef FEEDER_HOLD_EN
    logic                  skid_vld;
    logic [DATA_WIDTH-1:0] skid;

    assign hold = hold_in;

    // A stall that lands on SEND would lose the RAM word, which is only
    // valid for that one cycle; park it until the stall lifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_vld <= 1'b0;
            skid     <= '0;
        end else if (state == S_SEND && hold && !skid_vld) begin
            skid_vld <= 1'b1;
            skid     <= mem_rd_data;
        end else if (send_fire) begin
            skid_vld <= 1'b0;
        end
    end

    assign pix = skid_vld ? skid : mem_rd_data;
`else
    assign hold = 1'b0;
    assign pix  = mem_rd_data;
`endif

    assign send_fire = (state == S_SEND) && !hold;
    assign mem_rd_en = (state == S_FETCH) && !hold;
    assign mem_addr  = addr;
    // done is registered off FIN, so busy covers the done cycle explicitly.
    assign busy      = (state != S_IDLE) || done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d  = state;
        accept   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = PG_LOAD;
        if (!hold) begin
            case (state)
                // The done cycle is still part of the frame: no restart there.
                S_IDLE: if (start && !done) begin
                    state_d = S_FETCH;
                    accept  = 1'b1;
                end
                S_FETCH: state_d = S_SEND;
                S_SEND: begin
                    tmr_load = 1'b1;
                    if (col == COL_LAST) begin
                        if (row == ROW_LAST) begin
                            state_d = S_FIN;
                        end else begin
                            state_d = S_RGAP;
                            tmr_val = RG_LOAD;
                        end
                    end else begin
                        state_d = S_PGAP;
                    end
                end
                S_PGAP, S_RGAP: if (tmr_exp) state_d = S_FETCH;
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    stream_gap_timer #(
        .W (GW)
    ) u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (!hold),
        .load_val (tmr_val),
        .expire   (tmr_exp)
    );

    // Position advances as each pixel leaves so FETCH always sees the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (accept) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (send_fire) begin
            addr <= addr + 1'b1;
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            done      <= 1'b0;
        end else begin
            valid_out <= send_fire;
            done      <= (state == S_FIN) && !hold;
            if (send_fire) data_out <= pix;
        end
    end

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// tb_pixel_stream_feeder
//   Default 13x13 instance checked every cycle against a timing model that
//   places pulse k at start+3 + row*row_stride + col*(PIXEL_GAP+1); a 3x2
//   instance checked against hand-computed pulse times and data.
module tb_pixel_stream_feeder;

    localparam int DW = 16, W = 13, H = 13, PG = 5, RG = 100;
    localparam int N = W * H, AW = $clog2(N);
    localparam int PER = PG + 1;
    localparam int RSTRIDE = (W - 1) * PER + RG + 1;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold0 = 1'b0;
    logic mem_rd_en, valid_out, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0, data_out;
    logic [DW-1:0] ram [N];

    logic s_start = 1'b0;
    logic s_rd_en, s_valid, s_busy, s_done;
    logic [2:0] s_addr;
    logic [DW-1:0] s_rd_data = '0, s_data;
    logic [DW-1:0] sram [6];
`ifdef FEEDER_HOLD_EN
    logic s_hold = 1'b0;
`endif

    int vectors = 0, miscompares = 0;
    int cyc = 0, t_start = -1, idle_from = 0, frame_no = 0;
    int pulse_cnt [4];
    int done_cnt = 0, done_cyc = -1, f2_first = -1, k, kr, lp;
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] f2_data [$];
    int s_t [$];
    logic [DW-1:0] s_d [$];
    int s_done_t = -1, ts = 0, s_off [6], s_done_off;
    bit s_fin = 1'b0, got;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    always @(posedge clk) if (s_rd_en) s_rd_data <= sram[s_addr];

    pixel_stream_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef FEEDER_HOLD_EN
        .hold_in(hold0),
`endif
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .valid_out(valid_out), .data_out(data_out), .busy(busy), .done(done)
    );

    pixel_stream_feeder #(
        .IN_WIDTH(3), .IN_HEIGHT(2), .PIXEL_GAP(5), .ROW_GAP(100)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start),
`ifdef FEEDER_HOLD_EN
        .hold_in(s_hold),
`endif
        .mem_rd_en(s_rd_en), .mem_addr(s_addr), .mem_rd_data(s_rd_data),
        .valid_out(s_valid), .data_out(s_data), .busy(s_busy), .done(s_done)
    );

    function automatic int last_pulse(input int t);
        return t + 3 + (H - 1) * RSTRIDE + (W - 1) * PER;
    endfunction

    // Index of the pixel pulsing in cycle c of the current frame, or -1.
    function automatic int pulse_idx(input int c, input int t0);
        int d, r, m;
        if (t0 < 0) return -1;
        d = c - t0 - 3;
        if (d < 0) return -1;
        r = d / RSTRIDE;
        m = d % RSTRIDE;
        if (r < H && (m % PER) == 0 && (m / PER) < W) return r * W + m / PER;
        return -1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) ram[i] = DW'(i);
        for (int i = 0; i < 6; i++) sram[i] = DW'(i + 1);
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
`ifdef FEEDER_HOLD_EN
        s_off = '{3, 19, 25, 126, 132, 138};
        s_done_off = 139;
`else
        s_off = '{3, 9, 15, 116, 122, 128};
        s_done_off = 129;
`endif

        fork
            // Model: frame acceptance and cycle count.
            forever begin
                @(posedge clk);
                if (!rst_n) begin
                    t_start = -1;
                    idle_from = 0;
                end else if (start && cyc >= idle_from) begin
                    t_start = cyc;
                    idle_from = last_pulse(cyc) + 2;
                    if (frame_no < 3) frame_no++;
                end
                cyc++;
            end
            // Per-cycle compare.
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    check("rst_valid_out", valid_out, 0);
                    check("rst_data_out", data_out, 0);
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    check("rst_mem_rd_en", mem_rd_en, 0);
                    check("rst_mem_addr", mem_addr, 0);
                    last_data = '0;
                end else begin
                    k = pulse_idx(cyc, t_start);
                    kr = pulse_idx(cyc + 2, t_start);
                    lp = (t_start >= 0) ? last_pulse(t_start) : -10;
                    if (k >= 0) last_data = ram[k];
                    check("valid_out", valid_out, k >= 0);
                    check("data_out", data_out, last_data);
                    check("mem_rd_en", mem_rd_en, kr >= 0);
                    if (kr >= 0) check("mem_addr", mem_addr, kr);
                    check("busy", busy, t_start >= 0 && cyc >= t_start + 1 && cyc <= lp + 1);
                    check("done", done, t_start >= 0 && cyc == lp + 1);
                    if (valid_out) begin
                        pulse_cnt[frame_no]++;
                        if (frame_no == 2) begin
                            if (f2_first < 0) f2_first = cyc;
                            f2_data.push_back(data_out);
                        end
                    end
                    if (done) begin
                        done_cnt++;
                        done_cyc = cyc;
                    end
                end
                if (s_valid) begin
                    s_t.push_back(cyc);
                    s_d.push_back(s_data);
                end
                if (s_done) s_done_t = cyc;
            end
            // Small 3x2 instance: hand-computed schedule.
            begin
                do @(posedge clk); while (cyc < 20);
                #2 s_start = 1'b1;
                ts = cyc;
                @(posedge clk);
                #2 s_start = 1'b0;
`ifdef FEEDER_HOLD_EN
                do @(posedge clk); while (cyc < ts + 8);
                #2 s_hold = 1'b1;
                repeat (10) @(posedge clk);
                #2 s_hold = 1'b0;
`endif
                got = 1'b0;
                for (int i = 0; i < 400 && !got; i++) begin
                    @(posedge clk);
                    #2 if (s_done_t >= 0) got = 1'b1;
                end
                check("small_done_seen", got, 1);
                check("small_pulse_count", s_t.size(), 6);
                for (int i = 0; i < 6 && i < s_t.size(); i++) begin
                    check($sformatf("small_pulse%0d_time", i), s_t[i] - ts, s_off[i]);
                    check($sformatf("small_pulse%0d_data", i), s_d[i], i + 1);
                end
                check("small_done_time", s_done_t - ts, s_done_off);
                s_fin = 1'b1;
            end
        join_none

        // Reset, then frame 1 with RAM = index.
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        do @(posedge clk); while (cyc < 10);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        // start while busy must be ignored.
        repeat (50) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (700) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;

        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clk);
            #2 if (done) got = 1'b1;
        end
        check("frame1_done_seen", got, 1);

        // Held start from the done cycle: ignored there, accepted next cycle.
        ram[5] = 16'hFF9C;
        ram[6] = 16'h8000;
        start = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2 start = 1'b0;

        // Abort frame 2 after pixel 6, then stay idle.
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (300) @(posedge clk);

        for (int i = 0; i < 500 && !s_fin; i++) @(posedge clk);
        check("small_test_finished", s_fin, 1);

        check("frame1_pulses", pulse_cnt[1], N);
        check("done_count", done_cnt, 1);
        check("frame2_first_after_done", f2_first - done_cyc, 4);
        check("frame2_pulses_before_abort", f2_data.size(), 7);
        if (f2_data.size() >= 7) begin
            check("sign_neg100", f2_data[5], 16'hFF9C);
            check("sign_min", f2_data[6], 16'h8000);
        end
        check("frames_started", frame_no, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
